text_scroll: RTL and testbench
==============================

TEXT_SCROLL -- requirements
Module: text_scroll

Interface
REQ-001 Parameter COLS, default 32, text columns; power of two.
REQ-002 Parameter ROWS, default 30, text rows; ROWS <= 32.
REQ-003 Parameter COLOR_BITS, default 1, color-select width taken from tile MSBs.
REQ-004 Parameter TXBL_BASE, default 12'h900, VRAM base address of the text table.
REQ-005 cpu_clk  in  1  sole clock; all logic rising-edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 pixel_valid_i  in  1  display_x_i/display_y_i valid this cycle.
REQ-008 display_x_i, display_y_i  in  8 each  screen pixel coordinate.
REQ-009 frame_start_i  in  1  one-cycle pulse at start of vertical blank.
REQ-010 scroll_x_i, scroll_y_i  in  8 each  requested pixel scroll offsets.
REQ-011 clear_req_i  in  1  pulse requesting hardware clear of the text table.
REQ-012 display_strobe_o  out  1  display outputs valid this cycle.
REQ-013 display_color_o  out  COLOR_BITS  tile color select.
REQ-014 display_valid_o  out  1  pattern pixel set.
REQ-015 busy_o  out  1  clear engine active.
REQ-016 vram_wdata_i  in  mapache64::data_t; vram_rdata_o  out  mapache64::data_t; vram_address_i  in  mapache64::vram_address_t; vram_wen_i  in  1; SELECT_txbl_i  in  1.

Function
REQ-017 Table index = address - TXBL_BASE, truncated to log2(COLS)+5 bits; tile = {color[COLOR_BITS], pmca[8-COLOR_BITS]}, pattern line = PMC[{pmca, line}], pixel = line[7-intx].
REQ-018 CPU write: vram_wen_i && SELECT_txbl_i stores vram_wdata_i on the same rising edge.
REQ-019 CPU read: vram_rdata_o = table entry at vram_address_i, registered, valid one cycle after the address; 0 when SELECT_txbl_i was low.
REQ-020 Scroll offsets latched into active registers only on frame_start_i; mid-frame changes invisible until the next pulse.
REQ-021 Effective x = (display_x_i + scroll_x) mod 256, then mod COLS*8; effective y = display_y_i + scroll_y, minus ROWS*8 when >= ROWS*8 (vertical wrap at 240 by default).
REQ-022 Two-stage pipeline: stage 1 tile read, stage 2 pattern read; strobe, color and valid appear exactly 2 cycles after pixel_valid_i, one pixel per cycle, no stalls.
REQ-023 Clear FSM states IDLE, CLEAR; IDLE->CLEAR on clear_req_i; busy_o high from the next cycle.
REQ-024 CLEAR writes 0 to index 0..COLS*ROWS-1, one per cycle, ascending; CLEAR->IDLE after the last index; busy_o low the cycle after.
REQ-025 Simultaneous CPU write and clear write: CPU write wins; the clear counter holds that cycle and retries the same index next cycle.
REQ-026 clear_req_i while busy_o is high is ignored.
REQ-027 Display and CPU reads continue during CLEAR and return current content.

Reset
REQ-028 rst_n low: FSM IDLE, counter 0, busy_o 0, scroll registers 0, pipeline strobe 0, display_color_o 0, display_valid_o 0, vram_rdata_o 0.
REQ-029 Reset during CLEAR aborts immediately; table contents are not reset, and entries not yet cleared keep their values.

Structure
REQ-030 txbl_tile_t parameterised fields, TXBL_BASE default, PMC depth constant: in mapache64 package.
REQ-031 One sub-module, text_clear_fsm (counter, FSM, busy), instantiated once.

Verification
REQ-032 Write 8'h81 to 12'h900, then read -> vram_rdata_o = 8'h81 one cycle later.
REQ-033 Tile(0,0)=8'h81, PMC line 0 = 8'b1000_0000, pixel (0,0) -> strobe 2 cycles later, color 1, valid 1; pixel (1,0) -> valid 0.
REQ-034 scroll_y_i=8 with frame_start_i, pixel y=232 -> row 0 tile shown; scroll changed mid-frame -> no output change.
REQ-035 clear_req_i -> busy_o high for COLS*ROWS (960) cycles; all entries read back 0.
REQ-036 CPU write of 8'h55 to index 5 during clear at index 5 -> clear ends one cycle late; index 5 = 0; write at index 900 after pass -> 8'h55 kept.
REQ-037 rst_n low at clear index 100 -> busy_o 0 immediately; index 100+ retain prior data.

Source files
------------

// File: rtl/mapache64.sv
// Shared types and constants for the mapache64 video system: VRAM bus types,
// the text-table tile layout, the pattern-memory (PMC) contents and the
// clear-engine state encoding.
package mapache64;

  typedef logic [7:0]  data_t;
  typedef logic [11:0] vram_address_t;

  // Default location of the text table in VRAM.
  localparam vram_address_t TXBL_BASE_DEFAULT = 12'h900;

  // Default tile layout: color select in the MSBs, pattern id below it.
  localparam int TXBL_COLOR_BITS_DEFAULT = 1;
  localparam int TXBL_PMCA_BITS_DEFAULT  = 8 - TXBL_COLOR_BITS_DEFAULT;

  typedef struct packed {
    logic [TXBL_COLOR_BITS_DEFAULT-1:0] color;
    logic [TXBL_PMCA_BITS_DEFAULT-1:0]  pmca;
  } txbl_tile_t;

  // Pattern memory: up to 256 pattern ids, 8 lines each, one byte per line.
  localparam int PMC_LINES = 8;
  localparam int PMC_DEPTH = 256 * PMC_LINES;
  localparam int PMC_AW    = 11;

  // Clear engine states.
  typedef enum logic {
    CLR_IDLE  = 1'b0,
    CLR_CLEAR = 1'b1
  } clear_state_t;

  // Fixed pattern ROM. Address is {pattern id, line}. Pattern 0 is blank;
  // every other pattern is a diagonal stroke whose start column depends on
  // the id, with the rightmost pixel lit on ids that have bit 3 set.
  function automatic data_t pmc_line(input logic [PMC_AW-1:0] addr);
    logic [7:0] pm;
    logic [2:0] sh;
    data_t      bits;
    pm   = addr[PMC_AW-1:3];
    sh   = pm[2:0] + addr[2:0] - 3'd1;
    bits = (8'h80 >> sh) | {7'd0, pm[3]};
    if (pm == 8'd0) begin
      bits = '0;
    end
    return bits;
  endfunction

endpackage

// File: rtl/text_clear_fsm.sv
// Hardware clear engine for the text table: walks the table index from 0 to
// LAST one entry per cycle. A stall cycle (CPU write owns the write port)
// holds the index so the same entry is retried on the next cycle.
module text_clear_fsm
  import mapache64::*;
#(
  parameter int IW   = 10,
  parameter int LAST = 959
) (
  input  logic          cpu_clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          stall,
  output logic          busy,
  output logic [IW-1:0] addr,
  output clear_state_t  state
);

  localparam logic [IW-1:0] LAST_IDX = IW'(LAST);

  // Clear sequencing: start is ignored while a clear is already running.
  always_ff @(posedge cpu_clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CLR_IDLE;
      addr  <= '0;
      busy  <= 1'b0;
    end else begin
      case (state)
        CLR_IDLE: begin
          if (start) begin
            state <= CLR_CLEAR;
            addr  <= '0;
            busy  <= 1'b1;
          end
        end
        CLR_CLEAR: begin
          if (!stall) begin
            if (addr == LAST_IDX) begin
              state <= CLR_IDLE;
              addr  <= '0;
              busy  <= 1'b0;
            end else begin
              addr <= addr + IW'(1);
            end
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/text_scroll.sv
// Scrolling text-layer renderer. Holds the text table (one tile byte per
// cell), serves CPU reads/writes to it, renders one pixel per cycle through
// a two-stage pipeline (tile fetch, pattern fetch) and owns a hardware clear
// engine that zeroes the visible part of the table.
module text_scroll
  import mapache64::*;
#(
  parameter int            COLS       = 32,
  parameter int            ROWS       = 30,
  parameter int            COLOR_BITS = 1,
  parameter vram_address_t TXBL_BASE  = TXBL_BASE_DEFAULT
) (
  input  logic                  cpu_clk,
  input  logic                  rst_n,
  input  logic                  pixel_valid_i,
  input  logic [7:0]            display_x_i,
  input  logic [7:0]            display_y_i,
  input  logic                  frame_start_i,
  input  logic [7:0]            scroll_x_i,
  input  logic [7:0]            scroll_y_i,
  input  logic                  clear_req_i,
  output logic                  display_strobe_o,
  output logic [COLOR_BITS-1:0] display_color_o,
  output logic                  display_valid_o,
  output logic                  busy_o,
  input  data_t                 vram_wdata_i,
  output data_t                 vram_rdata_o,
  input  vram_address_t         vram_address_i,
  input  logic                  vram_wen_i,
  input  logic                  SELECT_txbl_i
);

  localparam int            COL_W  = $clog2(COLS);
  localparam int            IW     = COL_W + 5;
  localparam int            DEPTH  = 1 << IW;
  localparam int            PM_W   = 8 - COLOR_BITS;
  localparam logic [8:0]    Y_WRAP = 9'(ROWS * 8);

  data_t table_mem [DEPTH];

  // CPU port decode
  vram_address_t cpu_off;
  logic [IW-1:0] cpu_idx;
  logic          cpu_we;

  assign cpu_off = vram_address_i - TXBL_BASE;
  assign cpu_idx = cpu_off[IW-1:0];
  assign cpu_we  = vram_wen_i && SELECT_txbl_i;

  // Clear engine; a CPU write in the same cycle takes the write port.
  clear_state_t  clear_state;
  logic          clear_busy;
  logic [IW-1:0] clear_addr;
  logic          clear_we;

  text_clear_fsm #(
    .IW   (IW),
    .LAST (COLS * ROWS - 1)
  ) u_clear (
    .cpu_clk (cpu_clk),
    .rst_n   (rst_n),
    .start   (clear_req_i),
    .stall   (cpu_we),
    .busy    (clear_busy),
    .addr    (clear_addr),
    .state   (clear_state)
  );

  assign clear_we = (clear_state == CLR_CLEAR) && !cpu_we;
  assign busy_o   = clear_busy;

  // Single write port: CPU write has priority over the clear engine.
  always_ff @(posedge cpu_clk) begin
    if (cpu_we) begin
      table_mem[cpu_idx] <= vram_wdata_i;
    end else if (clear_we) begin
      table_mem[clear_addr] <= '0;
    end
  end

  // Registered CPU read; returns the value held before any same-edge write.
  always_ff @(posedge cpu_clk or negedge rst_n) begin
    if (!rst_n) begin
      vram_rdata_o <= '0;
    end else begin
      vram_rdata_o <= SELECT_txbl_i ? table_mem[cpu_idx] : '0;
    end
  end

  // Active scroll offsets only change at the start of vertical blank.
  logic [7:0] scroll_x_q;
  logic [7:0] scroll_y_q;

  always_ff @(posedge cpu_clk or negedge rst_n) begin
    if (!rst_n) begin
      scroll_x_q <= '0;
      scroll_y_q <= '0;
    end else if (frame_start_i) begin
      scroll_x_q <= scroll_x_i;
      scroll_y_q <= scroll_y_i;
    end
  end

  // Scrolled coordinate -> table index. COLS is a power of two, so the
  // horizontal wrap is just the column bits of the 8-bit sum.
  logic [7:0]       x_eff;
  logic [8:0]       y_sum;
  logic [8:0]       y_eff;
  logic [12:0]      x_ext;
  logic [COL_W-1:0] disp_col;
  logic [4:0]       disp_row;
  logic [IW-1:0]    disp_idx;

  always_comb begin
    x_eff    = display_x_i + scroll_x_q;
    y_sum    = {1'b0, display_y_i} + {1'b0, scroll_y_q};
    y_eff    = (y_sum >= Y_WRAP) ? (y_sum - Y_WRAP) : y_sum;
    x_ext    = {5'd0, x_eff};
    disp_col = x_ext[3 +: COL_W];
    disp_row = y_eff[7:3];
    disp_idx = {disp_row, disp_col};
  end

  // Stage 1: fetch the tile and remember the in-tile line and column.
  logic       s1_valid;
  data_t      s1_tile;
  logic [2:0] s1_line;
  logic [2:0] s1_intx;

  always_ff @(posedge cpu_clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_tile  <= '0;
      s1_line  <= '0;
      s1_intx  <= '0;
    end else begin
      s1_valid <= pixel_valid_i;
      if (pixel_valid_i) begin
        s1_tile <= table_mem[disp_idx];
        s1_line <= y_eff[2:0];
        s1_intx <= x_eff[2:0];
      end
    end
  end

  // Stage 2 lookup: pattern line for the fetched tile, then pick the pixel.
  logic [PMC_AW-1:0] pmc_addr;
  data_t             pattern;
  logic              pix;

  always_comb begin
    pmc_addr             = '0;
    pmc_addr[PM_W+2:0]   = {s1_tile[PM_W-1:0], s1_line};
    pattern              = pmc_line(pmc_addr);
    pix                  = pattern[3'd7 - s1_intx];
  end

  // Stage 2 register: display outputs, zeroed on cycles without a pixel.
  always_ff @(posedge cpu_clk or negedge rst_n) begin
    if (!rst_n) begin
      display_strobe_o <= 1'b0;
      display_color_o  <= '0;
      display_valid_o  <= 1'b0;
    end else begin
      display_strobe_o <= s1_valid;
      display_color_o  <= s1_valid ? s1_tile[7 -: COLOR_BITS] : '0;
      display_valid_o  <= s1_valid && pix;
    end
  end

  // Address bits above the table index and carry bits of the coordinate math
  // are intentionally dropped.
  logic unused_ok;
  assign unused_ok = ^{cpu_off, x_ext, y_eff};

endmodule

// File: tb/tb_text_scroll.sv
// Self-checking bench for text_scroll: fixed pixel vectors, hand sequences for
// scroll latching, latency and the clear engine, and a randomized phase
// checked against a coordinate-level reference model of the text layer.
module tb_text_scroll;
  import mapache64::*;

  localparam int            COLS  = 32;
  localparam int            ROWS  = 30;
  localparam int            CB    = 1;
  localparam int            NCELL = COLS * ROWS;
  localparam int            DEPTH = 1024;
  localparam vram_address_t BASE  = 12'h900;

  logic          cpu_clk;
  logic          rst_n;
  logic          pixel_valid_i;
  logic [7:0]    display_x_i;
  logic [7:0]    display_y_i;
  logic          frame_start_i;
  logic [7:0]    scroll_x_i;
  logic [7:0]    scroll_y_i;
  logic          clear_req_i;
  logic          display_strobe_o;
  logic [CB-1:0] display_color_o;
  logic          display_valid_o;
  logic          busy_o;
  data_t         vram_wdata_i;
  data_t         vram_rdata_o;
  vram_address_t vram_address_i;
  logic          vram_wen_i;
  logic          SELECT_txbl_i;

  text_scroll #(
    .COLS       (COLS),
    .ROWS       (ROWS),
    .COLOR_BITS (CB),
    .TXBL_BASE  (BASE)
  ) dut (
    .cpu_clk          (cpu_clk),
    .rst_n            (rst_n),
    .pixel_valid_i    (pixel_valid_i),
    .display_x_i      (display_x_i),
    .display_y_i      (display_y_i),
    .frame_start_i    (frame_start_i),
    .scroll_x_i       (scroll_x_i),
    .scroll_y_i       (scroll_y_i),
    .clear_req_i      (clear_req_i),
    .display_strobe_o (display_strobe_o),
    .display_color_o  (display_color_o),
    .display_valid_o  (display_valid_o),
    .busy_o           (busy_o),
    .vram_wdata_i     (vram_wdata_i),
    .vram_rdata_o     (vram_rdata_o),
    .vram_address_i   (vram_address_i),
    .vram_wen_i       (vram_wen_i),
    .SELECT_txbl_i    (SELECT_txbl_i)
  );

  // ---------------- clock / reset ----------------
  initial cpu_clk = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required $finish");
    $fatal(1);
  end

  // ---------------- scoreboard state ----------------
  int            checks   = 0;
  int            failures = 0;
  logic [7:0]    tbl [DEPTH];
  int            act_sx = 0;
  int            act_sy = 0;
  logic [CB+1:0] exp_q [$];

  typedef struct {
    int            x;
    int            y;
    int            sx;
    int            sy;
    logic [CB-1:0] color;
    logic          valid;
  } vec_t;

  vec_t vecs [16];

  task automatic tick();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] model_pattern(input int pm, input int line);
    logic [7:0] pat;
    pat = 8'h00;
    if (pm != 0) begin
      pat[7 - ((pm - 1 + line) % 8)] = 1'b1;
      if ((pm / 8) % 2 == 1) pat[0] = 1'b1;
    end
    return pat;
  endfunction

  // Returns {color, valid} for screen pixel (x,y) under scroll (sx,sy).
  function automatic logic [CB:0] model_pixel(input int x, input int y, input int sx, input int sy);
    int         ex, ey, row, col, tile, pm;
    logic [7:0] pat;
    ex = ((x + sx) % 256) % (COLS * 8);
    ey = y + sy;
    if (ey >= ROWS * 8) ey = ey - ROWS * 8;
    row  = (ey / 8) % 32;
    col  = ex / 8;
    tile = int'(tbl[row * COLS + col]);
    pm   = tile % (1 << (8 - CB));
    pat  = model_pattern(pm, ey % 8);
    return {CB'(tile >> (8 - CB)), pat[7 - (ex % 8)]};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic cpu_write(input int idx, input logic [7:0] d);
    vram_address_i = BASE + 12'(idx);
    vram_wdata_i   = d;
    vram_wen_i     = 1'b1;
    SELECT_txbl_i  = 1'b1;
    tick();
    vram_wen_i     = 1'b0;
    tbl[idx]       = d;
  endtask

  task automatic cpu_read(input int idx, output logic [7:0] d);
    vram_address_i = BASE + 12'(idx);
    vram_wen_i     = 1'b0;
    SELECT_txbl_i  = 1'b1;
    tick();
    d = vram_rdata_o;
  endtask

  // Latch scroll, present one pixel, return outputs one and two edges later.
  task automatic apply_pixel(input int x, input int y, input int sx, input int sy,
                             output logic early, output logic strobe,
                             output logic [CB-1:0] color, output logic valid);
    scroll_x_i    = 8'(sx);
    scroll_y_i    = 8'(sy);
    frame_start_i = 1'b1;
    tick();
    frame_start_i = 1'b0;
    pixel_valid_i = 1'b1;
    display_x_i   = 8'(x);
    display_y_i   = 8'(y);
    tick();
    early         = display_strobe_o;
    pixel_valid_i = 1'b0;
    tick();
    strobe = display_strobe_o;
    color  = display_color_o;
    valid  = display_valid_o;
  endtask

  // Run one clear pass with an optional CPU write at loop step wr_at and a
  // redundant clear request at step 500; returns busy-high cycle count.
  task automatic run_clear(input int wr_at, input int wr_idx, input logic [7:0] wr_data,
                           output int n);
    clear_req_i = 1'b1;
    tick();
    clear_req_i = 1'b0;
    n = 0;
    while (busy_o && n < 3000) begin
      n++;
      clear_req_i = (n == 500);
      if (n == wr_at) begin
        vram_address_i = BASE + 12'(wr_idx);
        vram_wdata_i   = wr_data;
        vram_wen_i     = 1'b1;
        SELECT_txbl_i  = 1'b1;
      end else begin
        vram_wen_i = 1'b0;
      end
      tick();
    end
    vram_wen_i  = 1'b0;
    clear_req_i = 1'b0;
    // Clear has zeroed every visible cell; the CPU write survives only when
    // its cell was already passed (clear index wr_at-1 was pending then).
    for (int i = 0; i < NCELL; i++) tbl[i] = 8'h00;
    if (wr_at > 0 && wr_idx < wr_at - 1) tbl[wr_idx] = wr_data;
    if (wr_at > 0 && wr_idx >= NCELL) tbl[wr_idx] = wr_data;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [7:0]    rd;
    logic          early, strobe, valid;
    logic [CB-1:0] color;
    int            n;

    rst_n          = 1'b0;
    pixel_valid_i  = 1'b0;
    display_x_i    = '0;
    display_y_i    = '0;
    frame_start_i  = 1'b0;
    scroll_x_i     = '0;
    scroll_y_i     = '0;
    clear_req_i    = 1'b0;
    vram_wdata_i   = '0;
    vram_address_i = '0;
    vram_wen_i     = 1'b0;
    SELECT_txbl_i  = 1'b0;
    repeat (3) tick();

    check("reset_busy",   32'(busy_o), 0);
    check("reset_strobe", 32'(display_strobe_o), 0);
    check("reset_color",  32'(display_color_o), 0);
    check("reset_valid",  32'(display_valid_o), 0);
    check("reset_rdata",  32'(vram_rdata_o), 0);
    rst_n = 1'b1;
    tick();

    // Write then read back at the table base.
    cpu_write(0, 8'h81);
    cpu_read(0, rd);
    check("rd_base", 32'(rd), 32'h81);
    SELECT_txbl_i = 1'b0;
    tick();
    check("rd_unselected", 32'(vram_rdata_o), 0);

    // Fill the whole table with random bytes, then plant known tiles.
    for (int i = 0; i < DEPTH; i++) cpu_write(i, 8'($urandom_range(0, 255)));
    cpu_write(0,   8'h81);
    cpu_write(1,   8'h0A);
    cpu_write(959, 8'hFF);
    for (int k = 0; k < 6; k++) begin
      int idx;
      idx = (k < 3) ? k * 479 : $urandom_range(0, DEPTH - 1);
      cpu_read(idx, rd);
      check($sformatf("rd_fill_%0d", idx), 32'(rd), 32'(tbl[idx]));
    end

    // Fixed pixel vectors: {x, y, sx, sy, color, valid}.
    vecs[0]  = '{0,   0,   0,   0,   1'b1, 1'b1};
    vecs[1]  = '{1,   0,   0,   0,   1'b1, 1'b0};
    vecs[2]  = '{1,   1,   0,   0,   1'b1, 1'b1};
    vecs[3]  = '{7,   7,   0,   0,   1'b1, 1'b1};
    vecs[4]  = '{8,   0,   0,   0,   1'b0, 1'b0};
    vecs[5]  = '{9,   0,   0,   0,   1'b0, 1'b1};
    vecs[6]  = '{15,  0,   0,   0,   1'b0, 1'b1};
    vecs[7]  = '{12,  3,   0,   0,   1'b0, 1'b1};
    vecs[8]  = '{13,  3,   0,   0,   1'b0, 1'b0};
    vecs[9]  = '{0,   232, 0,   8,   1'b1, 1'b1};
    vecs[10] = '{1,   232, 0,   8,   1'b1, 1'b0};
    vecs[11] = '{1,   0,   8,   0,   1'b0, 1'b1};
    vecs[12] = '{6,   0,   250, 0,   1'b1, 1'b1};
    vecs[13] = '{254, 232, 0,   0,   1'b1, 1'b1};
    vecs[14] = '{250, 232, 0,   0,   1'b1, 1'b0};
    vecs[15] = '{0,   1,   0,   239, 1'b1, 1'b1};

    for (int v = 0; v < 16; v++) begin
      apply_pixel(vecs[v].x, vecs[v].y, vecs[v].sx, vecs[v].sy, early, strobe, color, valid);
      check($sformatf("vec%0d_early", v),  32'(early), 0);
      check($sformatf("vec%0d_strobe", v), 32'(strobe), 1);
      check($sformatf("vec%0d_color", v),  32'(color), 32'(vecs[v].color));
      check($sformatf("vec%0d_valid", v),  32'(valid), 32'(vecs[v].valid));
    end

    // Mid-frame scroll change must stay invisible until the next frame start.
    scroll_x_i    = 8'd0;
    scroll_y_i    = 8'd8;
    frame_start_i = 1'b1;
    tick();
    frame_start_i = 1'b0;
    scroll_y_i    = 8'd0;
    tick();
    pixel_valid_i = 1'b1;
    display_x_i   = 8'd0;
    display_y_i   = 8'd232;
    tick();
    pixel_valid_i = 1'b0;
    tick();
    check("midframe_valid", 32'(display_valid_o), 1);
    check("midframe_color", 32'(display_color_o), 1);

    // Randomized display traffic with CPU reads/writes and frame starts.
    scroll_x_i    = 8'($urandom_range(0, 255));
    scroll_y_i    = 8'($urandom_range(0, 255));
    frame_start_i = 1'b1;
    tick();
    frame_start_i = 1'b0;
    act_sx = int'(scroll_x_i);
    act_sy = int'(scroll_y_i);
    exp_q.delete();
    for (int c = 0; c < 402; c++) begin
      logic          pv, fs, wr, sel;
      int            idx, x, y;
      logic [7:0]    d, exp_rd;
      logic [CB:0]   px;
      logic [CB+1:0] got, e;
      pv  = (c < 400) && ($urandom_range(0, 3) != 0);
      fs  = (c < 400) && ($urandom_range(0, 15) == 0);
      wr  = (c < 400) && ($urandom_range(0, 3) == 0);
      sel = ($urandom_range(0, 7) != 0);
      idx = $urandom_range(0, DEPTH - 1);
      x   = $urandom_range(0, 255);
      y   = $urandom_range(0, 239);
      d   = 8'($urandom_range(0, 255));
      pixel_valid_i  = pv;
      display_x_i    = 8'(x);
      display_y_i    = 8'(y);
      frame_start_i  = fs;
      scroll_x_i     = 8'($urandom_range(0, 255));
      scroll_y_i     = 8'($urandom_range(0, 255));
      vram_address_i = BASE + 12'(idx);
      vram_wdata_i   = d;
      vram_wen_i     = wr;
      SELECT_txbl_i  = sel;
      px = model_pixel(x, y, act_sx, act_sy);
      exp_q.push_back(pv ? {1'b1, px} : '0);
      exp_rd = sel ? tbl[idx] : 8'h00;
      tick();
      check("rand_rdata", 32'(vram_rdata_o), 32'(exp_rd));
      if (fs) begin
        act_sx = int'(scroll_x_i);
        act_sy = int'(scroll_y_i);
      end
      if (wr && sel) tbl[idx] = d;
      if (exp_q.size() >= 2) begin
        e   = exp_q.pop_front();
        got = {display_strobe_o, display_color_o, display_valid_o};
        if (e[CB+1]) check("rand_pixel", 32'(got), 32'(e));
        else         check("rand_idle_strobe", 32'(display_strobe_o), 0);
      end
    end
    pixel_valid_i = 1'b0;
    frame_start_i = 1'b0;
    vram_wen_i    = 1'b0;

    // Full clear: busy for exactly one cycle per visible cell.
    run_clear(0, 0, 8'h00, n);
    check("clear_busy_cycles", 32'(n), 32'(NCELL));
    for (int i = 0; i < DEPTH; i++) begin
      cpu_read(i, rd);
      check("clear_readback", 32'(rd), 32'(tbl[i]));
    end

    // CPU write colliding with the clear at index 5.
    cpu_write(5, 8'h33);
    run_clear(6, 5, 8'h55, n);
    check("collide_busy_cycles", 32'(n), 32'(NCELL + 1));
    cpu_read(5, rd);
    check("collide_idx5", 32'(rd), 0);

    // CPU write to an already-cleared index survives.
    run_clear(950, 900, 8'h55, n);
    check("late_write_busy_cycles", 32'(n), 32'(NCELL + 1));
    cpu_read(900, rd);
    check("late_write_idx900", 32'(rd), 32'h55);

    // Reset while the clear is at index 100 aborts it.
    for (int i = 0; i < 200; i++) cpu_write(i, 8'($urandom_range(0, 255)) | 8'h01);
    clear_req_i = 1'b1;
    tick();
    clear_req_i = 1'b0;
    n = 0;
    while (busy_o && n < 100) begin
      n++;
      tick();
    end
    check("abort_reached_100", 32'(n), 100);
    rst_n = 1'b0;
    #1;
    check("abort_busy_now", 32'(busy_o), 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("abort_busy_after", 32'(busy_o), 0);
    for (int i = 0; i < 100; i++) tbl[i] = 8'h00;
    for (int i = 90; i < 120; i++) begin
      cpu_read(i, rd);
      check($sformatf("abort_idx%0d", i), 32'(rd), 32'(tbl[i]));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
